// File: rtl/sd_sector_stream_reader.sv
// sd_sector_stream_reader: sequences single-block SD reads for a run of
// consecutive sectors, captures each sector into a 2-bank ping-pong
// buffer and re-emits the bytes as a valid/ready stream.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start               one-cycle pulse, latches base_sector/num_sectors
//   base_sector         first sector address
//   num_sectors         sectors to read, 0 is a no-op (done only)
//   busy                high from accepted start until done
//   done                one-cycle pulse at end of run
//   error               sticky watchdog flag (timeout build only)
//   sd_rd, sd_address   read request to the SD SPI controller
//   sd_ready            controller idle/ready
//   sd_dout             controller data byte
//   sd_byte_available   controller byte strobe (level, edge-detected here)
//   m_data, m_valid     output byte stream
//   m_ready             downstream ready
//   m_last              final byte of the final sector
//
// Optional feature: define SD_STREAM_TIMEOUT_EN to enable the watchdog.

module sd_sector_stream_reader #(
  parameter int SECTOR_STEP    = 1,
  parameter int SECTOR_BYTES   = 512,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_sector,
  input  logic [15:0] num_sectors,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        sd_rd,
  output logic [31:0] sd_address,
  input  logic        sd_ready,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last
);

  localparam int IW = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SECTOR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BANK,
    S_ISSUE,
    S_CAPTURE,
    S_ADVANCE,
    S_DRAIN
  } state_t;

  state_t state;

  logic [31:0]   cur_addr;
  logic [15:0]   remaining;
  logic [15:0]   total;
  logic          wr_bank;
  logic [IW-1:0] wr_idx;
  logic          rd_bank;
  logic [IW-1:0] rd_idx;
  logic [15:0]   rd_sec;
  logic [1:0]    full;
  logic [1:0]    full_next;
  logic          byte_q;

  logic [7:0] mem [2][SECTOR_BYTES];

  logic rise;
  logic cap;
  logic take;
  logic rd_end;
  logic tmo;

  // A byte counts once per rising edge of the controller strobe,
  // however long the strobe is held.
  assign rise   = sd_byte_available & ~byte_q;
  assign cap    = (state == S_CAPTURE) && rise;
  assign take   = m_valid && m_ready;
  assign rd_end = (rd_idx == LAST_IDX);

  // The read side presents the current bank directly; the bank being
  // read is never written, so data holds steady under backpressure.
  assign m_valid = full[rd_bank];
  assign m_data  = m_valid ? mem[rd_bank][rd_idx] : 8'h00;
  assign m_last  = m_valid && rd_end && (rd_sec == total - 16'd1);

`ifdef SD_STREAM_TIMEOUT_EN
  logic [24:0] tcnt;
  logic        error_r;

  assign tmo = ((state == S_ISSUE) || (state == S_CAPTURE)) &&
               (tcnt >= 25'(TIMEOUT_CYCLES - 1));
  assign error = error_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt <= '0;
    end else if (state == S_WAIT_BANK || cap) begin
      tcnt <= '0;
    end else if (state == S_ISSUE || state == S_CAPTURE) begin
      tcnt <= tcnt + 25'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      error_r <= 1'b0;
    end else if (state == S_IDLE && start) begin
      error_r <= 1'b0;
    end else if (tmo) begin
      error_r <= 1'b1;
    end
  end
`else
  assign tmo   = 1'b0;
  assign error = 1'b0;
`endif

  // Set and clear always target different banks: a read is only issued
  // into an empty bank, so both updates can apply in the same cycle.
  always_comb begin
    full_next = full;
    if (take && rd_end) full_next[rd_bank] = 1'b0;
    if (state == S_ADVANCE) full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (cap) mem[wr_bank][wr_idx] <= sd_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      total      <= '0;
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      rd_sec     <= '0;
      full       <= 2'b00;
      byte_q     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sd_rd      <= 1'b0;
      sd_address <= '0;
    end else begin
      byte_q <= sd_byte_available;
      done   <= 1'b0;
      full   <= full_next;

      if (take) begin
        if (rd_end) begin
          rd_idx  <= '0;
          rd_bank <= ~rd_bank;
          rd_sec  <= rd_sec + 16'd1;
        end else begin
          rd_idx <= rd_idx + IW'(1);
        end
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (num_sectors == 16'd0) begin
              done <= 1'b1;
            end else begin
              cur_addr  <= base_sector;
              remaining <= num_sectors;
              total     <= num_sectors;
              wr_bank   <= 1'b0;
              wr_idx    <= '0;
              rd_bank   <= 1'b0;
              rd_idx    <= '0;
              rd_sec    <= '0;
              busy      <= 1'b1;
              state     <= S_WAIT_BANK;
            end
          end
        end
        S_WAIT_BANK: begin
          if (!full[wr_bank] && sd_ready) begin
            sd_address <= cur_addr;
            sd_rd      <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Controller drops ready once it has taken the request.
          if (!sd_ready) begin
            sd_rd <= 1'b0;
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (cap) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx <= '0;
              state  <= S_ADVANCE;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        S_ADVANCE: begin
          wr_bank   <= ~wr_bank;
          cur_addr  <= cur_addr + 32'(SECTOR_STEP);
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) state <= S_DRAIN;
          else state <= S_WAIT_BANK;
        end
        S_DRAIN: begin
          if (full == 2'b00) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Watchdog abort: drop the request, flush unread data, finish.
      if (tmo) begin
        sd_rd  <= 1'b0;
        full   <= 2'b00;
        rd_idx <= '0;
        wr_idx <= '0;
        done   <= 1'b1;
        busy   <= 1'b0;
        state  <= S_IDLE;
      end
    end
  end

endmodule
